// File: rtl/mem_seq_ctrl.sv
// Request sequencer for the 64x8 system memory: holds address/mode/data/erase pins for the memory latencies and returns a done pulse.
// Optional write-verify read-back is enabled by defining MEMSEQ_WRITE_VERIFY_EN.
module mem_seq_ctrl #(
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 3,
    parameter int AW        = 6,
    parameter int DW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic          erase_req,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          verr,
    output logic [AW-1:0] mem_adrs,
    output logic          mem_mode,
    output logic [DW-1:0] mem_data,
    output logic          mem_erase,
    input  logic [DW-1:0] mem_out
);

    localparam int MAXC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CW   = $clog2(MAXC + 2);

`ifdef MEMSEQ_WRITE_VERIFY_EN
    typedef enum logic [2:0] {IDLE, ERASE, RD, WR, VFY} state_t;
`else
    typedef enum logic [2:0] {IDLE, ERASE, RD, WR} state_t;
`endif

    state_t        state;
    logic [CW-1:0] cnt;

`ifdef MEMSEQ_WRITE_VERIFY_EN
    logic verr_q;
    assign verr = verr_q;
`else
    assign verr = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= '0;
            mem_adrs  <= '0;
            mem_mode  <= 1'b0;
            mem_data  <= '0;
            mem_erase <= 1'b0;
`ifdef MEMSEQ_WRITE_VERIFY_EN
            verr_q    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Erase wins; a req arriving in the same cycle is dropped, not queued.
                    if (erase_req) begin
                        state     <= ERASE;
                        busy      <= 1'b1;
                        mem_erase <= 1'b1;
                        cnt       <= '0;
                    end else if (req) begin
                        busy     <= 1'b1;
                        mem_adrs <= addr;
                        mem_data <= wdata;
                        if (we) begin
                            state    <= WR;
                            mem_mode <= 1'b1;
                            cnt      <= CW'(WR_CYCLES - 1);
                        end else begin
                            state    <= RD;
                            mem_mode <= 1'b0;
                            cnt      <= CW'(RD_CYCLES);
                        end
                    end
                end
                ERASE: begin
                    mem_erase <= 1'b0;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                RD: begin
                    if (cnt == '0) begin
                        rdata <= mem_out;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR: begin
                    if (cnt == '0) begin
                        mem_mode <= 1'b0;
`ifdef MEMSEQ_WRITE_VERIFY_EN
                        // Keep the address and data for the read-back compare.
                        state    <= VFY;
                        cnt      <= CW'(RD_CYCLES);
`else
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef MEMSEQ_WRITE_VERIFY_EN
                VFY: begin
                    if (cnt == '0) begin
                        if (mem_out != mem_data) verr_q <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    mem_mode  <= 1'b0;
                    mem_erase <= 1'b0;
                end
            endcase
        end
    end

endmodule
